// File: rtl/maze_player_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : maze_player_ctrl
//  Purpose  : Sprite controller for the 25x25 maze. Holds the sprite cell,
//             turns direction-button rising edges into single-cell moves,
//             rejects moves into WALL cells or off the grid (bump pulse),
//             enforces a post-move cooldown and latches arrival at the
//             treasure cell (won).
//  Ports    : clk, resetn (async active-low)
//             maze[GRID*GRID-1:0] bitmap (1=PATH 0=WALL), maze_done valid
//             restart sync pulse, btn_up/down/left/right level inputs
//             player_x/player_y sprite cell, bump 1-cycle pulse,
//             won sticky flag, busy (CHECK or COOL)
//             move_count[9:0] (only when MOVE_COUNT_EN is defined)
//  Options  : MOVE_COUNT_EN - adds a saturating legal-move counter output
//  Revision : 1.0  initial release
// ============================================================================
module maze_player_ctrl #(
  parameter int unsigned GRID     = 25,
  parameter int unsigned START_X  = 1,
  parameter int unsigned START_Y  = 1,
  parameter int unsigned GOAL_X   = 23,
  parameter int unsigned GOAL_Y   = 23,
  parameter int unsigned COOL_CYC = 2500000
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic [GRID*GRID-1:0]   maze,
  input  logic                   maze_done,
  input  logic                   restart,
  input  logic                   btn_up,
  input  logic                   btn_down,
  input  logic                   btn_left,
  input  logic                   btn_right,
  output logic [4:0]             player_x,
  output logic [4:0]             player_y,
  output logic                   bump,
  output logic                   won,
  output logic                   busy
`ifdef MOVE_COUNT_EN
  ,
  output logic [9:0]             move_count
`endif
);

  localparam int CNT_W = (COOL_CYC > 1) ? $clog2(COOL_CYC) : 1;

  localparam logic [2:0] S_WAIT  = 3'd0;
  localparam logic [2:0] S_IDLE  = 3'd1;
  localparam logic [2:0] S_CHECK = 3'd2;
  localparam logic [2:0] S_COOL  = 3'd3;
  localparam logic [2:0] S_WON   = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [4:0]       px_q, px_d;
  logic [4:0]       py_q, py_d;
  logic [4:0]       tx_q, tx_d;
  logic [4:0]       ty_q, ty_d;
  logic             oob_q, oob_d;       // latched target lies outside the grid
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             bump_q, bump_d;
  logic             won_q, won_d;
  logic [3:0]       btn_prev_q;         // {up, down, left, right}
`ifdef MOVE_COUNT_EN
  logic [9:0]       mc_q, mc_d;
`endif

  logic [3:0] w_btn;
  logic [3:0] w_edge;
  logic [9:0] w_idx;
  logic       w_legal;

  assign w_btn  = {btn_up, btn_down, btn_left, btn_right};
  assign w_edge = w_btn & ~btn_prev_q;

  // Off-grid targets are forced to index 0 so the bitmap is never read out of
  // range; oob_q alone then decides the outcome.
  assign w_idx   = oob_q ? 10'd0 : (10'(ty_q) * 10'(GRID) + 10'(tx_q));
  assign w_legal = !oob_q && maze[w_idx];

  always_comb begin
    state_d = state_q;
    px_d    = px_q;
    py_d    = py_q;
    tx_d    = tx_q;
    ty_d    = ty_q;
    oob_d   = oob_q;
    cnt_d   = cnt_q;
    bump_d  = 1'b0;
    won_d   = won_q;
`ifdef MOVE_COUNT_EN
    mc_d    = mc_q;
`endif

    if (restart) begin
      // Restart outranks any simultaneous edge; WAIT stays in WAIT.
      px_d    = 5'(START_X);
      py_d    = 5'(START_Y);
      won_d   = 1'b0;
      cnt_d   = '0;
      state_d = (state_q == S_WAIT) ? S_WAIT : S_IDLE;
`ifdef MOVE_COUNT_EN
      mc_d    = '0;
`endif
    end else begin
      case (state_q)
        S_WAIT: begin
          if (maze_done) state_d = S_IDLE;
        end

        S_IDLE: begin
          if (!maze_done) begin
            state_d = S_WAIT;
          end else if (w_edge != 4'b0000) begin
            tx_d    = px_q;
            ty_d    = py_q;
            state_d = S_CHECK;
            if (w_edge[3]) begin
              ty_d  = py_q - 5'd1;
              oob_d = (py_q == 5'd0);
            end else if (w_edge[2]) begin
              ty_d  = py_q + 5'd1;
              oob_d = (py_q >= 5'(GRID - 1));
            end else if (w_edge[1]) begin
              tx_d  = px_q - 5'd1;
              oob_d = (px_q == 5'd0);
            end else begin
              tx_d  = px_q + 5'd1;
              oob_d = (px_q >= 5'(GRID - 1));
            end
          end
        end

        S_CHECK: begin
          if (!maze_done) begin
            state_d = S_WAIT;
          end else begin
            if (w_legal) begin
              px_d = tx_q;
              py_d = ty_q;
`ifdef MOVE_COUNT_EN
              if (mc_q != 10'h3FF) mc_d = mc_q + 10'd1;
`endif
            end else begin
              bump_d = 1'b1;
            end
            cnt_d   = '0;
            state_d = S_COOL;
          end
        end

        S_COOL: begin
          if (!maze_done) begin
            state_d = S_WAIT;
          end else if (cnt_q == CNT_W'(COOL_CYC - 1)) begin
            cnt_d = '0;
            if (px_q == 5'(GOAL_X) && py_q == 5'(GOAL_Y)) begin
              won_d   = 1'b1;
              state_d = S_WON;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end

        S_WON: begin
          state_d = S_WON;
        end

        default: begin
          state_d = S_WAIT;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= S_WAIT;
      px_q       <= 5'(START_X);
      py_q       <= 5'(START_Y);
      tx_q       <= '0;
      ty_q       <= '0;
      oob_q      <= 1'b0;
      cnt_q      <= '0;
      bump_q     <= 1'b0;
      won_q      <= 1'b0;
      btn_prev_q <= 4'b0000;
`ifdef MOVE_COUNT_EN
      mc_q       <= '0;
`endif
    end else begin
      state_q    <= state_d;
      px_q       <= px_d;
      py_q       <= py_d;
      tx_q       <= tx_d;
      ty_q       <= ty_d;
      oob_q      <= oob_d;
      cnt_q      <= cnt_d;
      bump_q     <= bump_d;
      won_q      <= won_d;
      btn_prev_q <= w_btn;
`ifdef MOVE_COUNT_EN
      mc_q       <= mc_d;
`endif
    end
  end

  assign player_x = px_q;
  assign player_y = py_q;
  assign bump     = bump_q;
  assign won      = won_q;
  assign busy     = (state_q == S_CHECK) || (state_q == S_COOL);
`ifdef MOVE_COUNT_EN
  assign move_count = mc_q;
`endif

endmodule
`default_nettype wire
